// File: rtl/axis_to_uart_tx.sv
// AXI-Stream to UART transmitter: accepts one word per handshake and serialises
// it as start, LSB-first data, optional parity and one or two stop bits.
module axis_to_uart_tx #(
  parameter int CLK_FREQ      = 100,
  parameter int BIT_RATE      = 115200,
  parameter int BIT_PER_WORD  = 8,
  parameter int PARITY_BIT    = 0,
  parameter int STOP_BITS_NUM = 1
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [BIT_PER_WORD-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic                    tx,
  output logic                    busy
);

  localparam int BIT_CYCLES = (CLK_FREQ * 1_000_000) / BIT_RATE;
  localparam int CW = (BIT_CYCLES < 2) ? 1 : $clog2(BIT_CYCLES);
  localparam int BW = $clog2(BIT_PER_WORD);
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(BIT_PER_WORD - 1);

  if (BIT_CYCLES < 2) begin : g_bad_rate
    $error("axis_to_uart_tx: BIT_CYCLES must be at least 2");
  end
  if (BIT_PER_WORD < 5 || BIT_PER_WORD > 9) begin : g_bad_width
    $error("axis_to_uart_tx: BIT_PER_WORD must be 5..9");
  end
  if (PARITY_BIT < 0 || PARITY_BIT > 2) begin : g_bad_parity
    $error("axis_to_uart_tx: PARITY_BIT must be 0, 1 or 2");
  end
  if (STOP_BITS_NUM < 1 || STOP_BITS_NUM > 2) begin : g_bad_stop
    $error("axis_to_uart_tx: STOP_BITS_NUM must be 1 or 2");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cyc_q, cyc_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [BIT_PER_WORD-1:0] shift_q, shift_d;
  logic                    parity_q, parity_d;
  logic                    tx_q, tx_d;
  logic                    tready_q, tready_d;
  logic                    bit_end;

  assign bit_end       = (cyc_q == CYC_LAST);
  assign s_axis_tready = tready_q;
  assign tx            = tx_q;
  assign busy          = (state_q != IDLE);

  // tx_d always carries the level of the bit that starts on the next edge,
  // so the registered line changes exactly on bit boundaries.
  always_comb begin
    state_d  = state_q;
    cyc_d    = bit_end ? '0 : cyc_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    tx_d     = tx_q;
    tready_d = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d     = 1'b1;
        tready_d = 1'b1;
        cyc_d    = '0;
        if (s_axis_tvalid && tready_q) begin
          shift_d  = s_axis_tdata;
          parity_d = (PARITY_BIT == 1) ? ~^s_axis_tdata : ^s_axis_tdata;
          bit_d    = '0;
          tx_d     = 1'b0;
          tready_d = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_LAST) begin
            if (PARITY_BIT != 0) begin
              tx_d    = parity_q;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP1;
            end
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            bit_d   = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = STOP1;
        end
      end
      STOP1: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (STOP_BITS_NUM == 2) begin
            state_d = STOP2;
          end else begin
            tready_d = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      STOP2: begin
        tx_d = 1'b1;
        if (bit_end) begin
          tready_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        cyc_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      cyc_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      tready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      tready_q <= tready_d;
    end
  end

endmodule

// File: doc/axis_to_uart_tx.md
# axis_to_uart_tx

Serialises AXI-Stream words onto a UART TX line with configurable word length, parity and stop bits. It accepts one word per handshake, holds it in a shift register and emits start, data (LSB first), optional parity and stop bits at the parameterised bit rate. It sits between an AXI-Stream producer and the pin-level UART TX line, as the transmit-side counterpart of the UART receive path.

## Interface
- CLK_FREQ, 100: clock frequency in MHz.
- BIT_RATE, 115200: line rate in bit/s.
- BIT_PER_WORD, 8: data bits per word, 5..9.
- PARITY_BIT, 0: parity mode. 0 = none, 1 = odd, 2 = even.
- STOP_BITS_NUM, 1: number of stop bits, 1 or 2.
- aclk  input  1  clock; all logic on the rising edge.
- aresetn  input  1  asynchronous, active-low reset.
- s_axis_tdata  input  BIT_PER_WORD  word to transmit.
- s_axis_tvalid  input  1  producer has a word.
- s_axis_tready  output  1  block can accept a word; registered.
- tx  output  1  UART serial line; idles high; registered.
- busy  output  1  a frame is in progress (any state other than IDLE).

## Operation
- BIT_CYCLES = (CLK_FREQ*1_000_000)/BIT_RATE, integer division, evaluated at elaboration. A BIT_CYCLES below 2 is an elaboration error.
- Bit counter and cycle counter widths are derived with $clog2 from BIT_PER_WORD and BIT_CYCLES.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE:
  - tx=1, s_axis_tready=1.
  - On s_axis_tvalid & s_axis_tready, the block latches tdata into the shift register and latches the parity bit, then moves to START.
  - Parity bit: even mode gives ^tdata; odd mode gives ~^tdata.
- START: tx=0 for BIT_CYCLES cycles, then DATA.
- DATA:
  - tx = shift register bit 0.
  - Every BIT_CYCLES cycles the register shifts right and the bit counter increments.
  - After BIT_PER_WORD bits the FSM goes to PARITY if PARITY_BIT≠0, else STOP1.
- PARITY: tx = latched parity bit for BIT_CYCLES cycles, then STOP1.
- STOP1: tx=1 for BIT_CYCLES cycles, then STOP2 if STOP_BITS_NUM==2, else IDLE.
- STOP2: tx=1 for BIT_CYCLES cycles, then IDLE.
- s_axis_tready is 0 in every state except IDLE. Changes on tdata or tvalid while busy have no effect.
- The cycle counter restarts at 0 on every bit boundary, so there is no cumulative drift.

## Timing
- Reset (asynchronous, immediate): tx=1, s_axis_tready=0, busy=0, FSM=IDLE, counters and shift register cleared.
- s_axis_tready rises on the first aclk edge after aresetn deasserts.
- Reset mid-frame aborts the frame: tx returns to 1 at once, the word is dropped and nothing is retransmitted.
- Handshake in cycle N: tx=0 and busy=1 from cycle N+1.
- Frame length F = BIT_CYCLES*(1+BIT_PER_WORD+(PARITY_BIT≠0)+STOP_BITS_NUM) cycles from the start-bit edge.
- The FSM is back in IDLE, with s_axis_tready=1 and busy=0, at cycle N+1+F.
- With tvalid held high, back-to-back words start every F+1 cycles; the line stays high for 1 extra cycle between frames.
- Each bit holds tx for exactly BIT_CYCLES cycles.
- No handshake is possible in any state other than IDLE; an accept and a new start on the same cycle cannot occur.

## Test plan
- Reset behaviour. Settings: CLK_FREQ=1, BIT_RATE=250000 (BIT_CYCLES=4), 8N1. Hold reset for 5 cycles, then release: tx=1 throughout; tready=0 during reset and 1 on the first edge after release.
- Single 8N1 word. Send 0xA5: tx reads 0 then 1,0,1,0,0,1,0,1 then 1, each bit 4 cycles. Frame is 40 cycles; tready is low for all of it.
- Parity and stop bits. Send 0x55 with 8E2: parity bit 0, two stop bits, 48-cycle frame. Repeat with 8O1: parity bit 1, 44-cycle frame.
- Back-to-back. Hold tvalid high and send 0x00 then 0xFF (8N1): start bits 41 cycles apart, and exactly one tready pulse per word.
- Ignored input while busy. Toggle tdata and tvalid during a frame: the transmitted bits match the word latched at the handshake, and no extra handshake occurs.
- Reset mid-frame. Assert aresetn low during DATA bit 3: tx=1 asynchronously and busy=0. After release, the next word is sent cleanly with no remnant bits.
